// File: rtl/key_sched_ctrl.sv
// Key schedule controller: launches key_exp, captures its writes into a 32x64 key RAM,
// and serves 128-bit round keys by round index. Optional EXPAND watchdog: KEY_SCHED_TIMEOUT_EN.
module key_sched_ctrl #(
  parameter int TIMEOUT_CYC = 200,
  parameter int MEM_DEPTH   = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic [255:0] load_key,
  input  logic [1:0]   load_mode,
  input  logic         cipher_busy,
  output logic         ke_start,
  output logic [255:0] ke_key,
  output logic [1:0]   ke_mode,
  input  logic         ke_wr,
  input  logic [4:0]   ke_wr_addr,
  input  logic [63:0]  ke_wr_data,
  input  logic         ke_ready,
  input  logic         rk_req,
  input  logic [3:0]   rk_round,
  output logic         rk_gnt,
  output logic         rk_valid,
  output logic [127:0] rk_data,
  output logic         rk_oor,
  output logic         keys_valid,
  output logic [3:0]   num_rounds,
  output logic         err
);

  typedef enum logic [1:0] {IDLE, LAUNCH, EXPAND, READY} state_t;

  state_t      state, state_nxt;
  logic        accept, done, tmo;
  logic [5:0]  wr_cnt, need;
  logic [1:0]  guard_cnt;
  logic [63:0] mem [MEM_DEPTH];

  function automatic logic [3:0] rounds_of(input logic [1:0] mode);
    case (mode)
      2'b00:   return 4'd10;
      2'b01:   return 4'd12;
      default: return 4'd14;
    endcase
  endfunction

  function automatic logic [1:0] norm_mode(input logic [1:0] mode);
    return (mode == 2'b11) ? 2'b10 : mode;
  endfunction

  assign accept = load_valid && load_ready;
  assign need   = {1'b0, num_rounds, 1'b0} + 6'd2;
  // key_exp still shows the previous done flag for two cycles after the start pulse
  assign done   = (guard_cnt == 2'd2) && ke_ready && (wr_cnt >= need);

`ifdef KEY_SCHED_TIMEOUT_EN
  logic [7:0] tmo_cnt;

  assign tmo = (state == EXPAND) && !done && (tmo_cnt == 8'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
      err     <= 1'b0;
    end else begin
      if (accept)                tmo_cnt <= '0;
      else if (state == EXPAND)  tmo_cnt <= tmo_cnt + 8'd1;
      if (accept)                err <= 1'b0;
      else if (tmo)              err <= 1'b1;
    end
  end
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = LAUNCH;
      LAUNCH:  state_nxt = EXPAND;
      EXPAND:  if (done) state_nxt = READY;
               else if (tmo) state_nxt = IDLE;
      READY:   if (accept) state_nxt = LAUNCH;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load_ready = 1'b0;
    ke_start   = 1'b0;
    rk_gnt     = 1'b0;
    load_ready = ((state == IDLE) || (state == READY)) && !cipher_busy;
    ke_start   = (state == LAUNCH);
    rk_gnt     = rk_req && (state == READY);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ke_key     <= '0;
      ke_mode    <= '0;
      num_rounds <= 4'd10;
      wr_cnt     <= '0;
      guard_cnt  <= '0;
      keys_valid <= 1'b0;
    end else begin
      if (accept) begin
        ke_key     <= load_key;
        ke_mode    <= norm_mode(load_mode);
        num_rounds <= rounds_of(load_mode);
      end
      if (accept)                          wr_cnt <= '0;
      else if (ke_wr && wr_cnt != 6'd63)   wr_cnt <= wr_cnt + 6'd1;
      if (accept)                                guard_cnt <= '0;
      else if (state == EXPAND && guard_cnt != 2'd2) guard_cnt <= guard_cnt + 2'd1;
      if (accept)                        keys_valid <= 1'b0;
      else if (state == EXPAND && done)  keys_valid <= 1'b1;
      else if (tmo)                      keys_valid <= 1'b0;
    end
  end

  // RAM write port; the read below samples pre-write contents on a same-address collision
  always_ff @(posedge clk) begin
    if (ke_wr) mem[ke_wr_addr] <= ke_wr_data;
  end

  // read stage: one registered round key per granted request
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rk_valid <= 1'b0;
      rk_oor   <= 1'b0;
      rk_data  <= '0;
    end else begin
      rk_valid <= rk_gnt;
      rk_oor   <= rk_gnt && (rk_round > num_rounds);
      if (rk_gnt) begin
        if (rk_round > num_rounds) rk_data <= '0;
        else rk_data <= {mem[{rk_round, 1'b0}], mem[{rk_round, 1'b1}]};
      end
    end
  end

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Directed bench for key_sched_ctrl; the bench plays key_exp, writing known words
// (including published AES round keys) into the key RAM and reading them back.
module tb_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         load_valid, load_ready;
  logic [255:0] load_key;
  logic [1:0]   load_mode;
  logic         cipher_busy, ke_start;
  logic [255:0] ke_key;
  logic [1:0]   ke_mode;
  logic         ke_wr;
  logic [4:0]   ke_wr_addr;
  logic [63:0]  ke_wr_data;
  logic         ke_ready, rk_req;
  logic [3:0]   rk_round;
  logic         rk_gnt, rk_valid;
  logic [127:0] rk_data;
  logic         rk_oor, keys_valid;
  logic [3:0]   num_rounds;
  logic         err;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_mem [32];

  localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] R10_128 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] R12_192 = 128'ha4970a331a78dc09c418c271e3a41d5d;
  localparam logic [127:0] R14_256 = 128'h24fc79ccbf0979e9371ac23c6d68de36;
  localparam logic [127:0] R0_256  = 128'h000102030405060708090a0b0c0d0e0f;

  always #5 clk = ~clk;

  key_sched_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .load_valid(load_valid), .load_ready(load_ready), .load_key(load_key),
    .load_mode(load_mode), .cipher_busy(cipher_busy),
    .ke_start(ke_start), .ke_key(ke_key), .ke_mode(ke_mode),
    .ke_wr(ke_wr), .ke_wr_addr(ke_wr_addr), .ke_wr_data(ke_wr_data), .ke_ready(ke_ready),
    .rk_req(rk_req), .rk_round(rk_round), .rk_gnt(rk_gnt), .rk_valid(rk_valid),
    .rk_data(rk_data), .rk_oor(rk_oor), .keys_valid(keys_valid),
    .num_rounds(num_rounds), .err(err)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic fill(input int ld);
    for (int i = 0; i < 32; i++) exp_mem[i] = {8'(ld), 48'h0, 8'(i)};
  endtask

  task automatic write_one(input int i);
    ke_wr      = 1'b1;
    ke_wr_addr = 5'(i);
    ke_wr_data = exp_mem[i];
  endtask

  task automatic do_load(input logic [255:0] key, input logic [1:0] mode, input logic [3:0] nr);
    cyc();
    load_valid = 1'b1; load_key = key; load_mode = mode;
    #1 chk("load_ready_at_accept", load_ready, 1'b1);
    cyc();
    load_valid = 1'b0;
    #1 chk("ke_start_launch", ke_start, 1'b1);
    chk("ke_key_latched", ke_key, key);
    chk("ke_mode_latched", ke_mode, mode);
    chk("keys_valid_cleared", keys_valid, 1'b0);
    chk("num_rounds_latched", num_rounds, nr);
    cyc();
    #1 chk("ke_start_one_cycle", ke_start, 1'b0);
  endtask

  task automatic finish_exp();
    cyc();
    ke_wr = 1'b0; ke_ready = 1'b1;
    cyc();
    ke_ready = 1'b0;
    #1 chk("keys_valid_set", keys_valid, 1'b1);
    chk("load_ready_in_ready", load_ready, 1'b1);
  endtask

  task automatic rd(input string tag, input logic [3:0] r, input logic [127:0] data, input logic oor);
    cyc();
    rk_req = 1'b1; rk_round = r;
    #1 chk({tag, "_gnt"}, rk_gnt, 1'b1);
    cyc();
    rk_req = 1'b0;
    #1 chk({tag, "_valid"}, rk_valid, 1'b1);
    chk({tag, "_oor"}, rk_oor, oor);
    chk({tag, "_data"}, rk_data, data);
  endtask

  initial begin
    reset_n = 1'b0; load_valid = 1'b0; load_key = '0; load_mode = '0; cipher_busy = 1'b0;
    ke_wr = 1'b0; ke_wr_addr = '0; ke_wr_data = '0; ke_ready = 1'b0;
    rk_req = 1'b0; rk_round = '0;
    cyc(); cyc();
    #1 chk("rst_load_ready", load_ready, 1'b1);
    chk("rst_ke_start", ke_start, 1'b0);
    chk("rst_ke_key", ke_key, '0);
    chk("rst_ke_mode", ke_mode, 2'b00);
    chk("rst_rk_valid", rk_valid, 1'b0);
    chk("rst_rk_oor", rk_oor, 1'b0);
    chk("rst_rk_data", rk_data, '0);
    chk("rst_keys_valid", keys_valid, 1'b0);
    chk("rst_num_rounds", num_rounds, 4'd10);
    chk("rst_err", err, 1'b0);
    cyc();
    reset_n = 1'b1;

    // 128-bit key
    fill(1);
    exp_mem[20] = R10_128[127:64];
    exp_mem[21] = R10_128[63:0];
    do_load(K128, 2'b00, 4'd10);
    rk_req = 1'b1; rk_round = 4'd0;
    #1 chk("gnt_blocked_expand", rk_gnt, 1'b0);
    chk("load_ready_expand", load_ready, 1'b0);
    for (int i = 0; i < 21; i++) begin
      cyc();
      write_one(i);
      if (i == 0) begin
        rk_req = 1'b0;
        #1 chk("no_valid_expand", rk_valid, 1'b0);
      end
    end
    cyc();
    write_one(21); ke_ready = 1'b1;
    #1 chk("kv_low_21_writes", keys_valid, 1'b0);
    cyc();
    ke_wr = 1'b0;
    #1 chk("kv_low_count_edge", keys_valid, 1'b0);
    cyc();
    ke_ready = 1'b0;
    #1 chk("kv_high_22_writes", keys_valid, 1'b1);
    chk("err_after_128", err, 1'b0);
    // back-to-back reads: round 10, round 3, out-of-range round 11
    cyc();
    rk_req = 1'b1; rk_round = 4'd10;
    #1 chk("b2b_gnt", rk_gnt, 1'b1);
    cyc();
    rk_round = 4'd3;
    #1 chk("r10_valid", rk_valid, 1'b1);
    chk("r10_data", rk_data, R10_128);
    chk("r10_oor", rk_oor, 1'b0);
    cyc();
    rk_round = 4'd11;
    #1 chk("r3_data", rk_data, {exp_mem[6], exp_mem[7]});
    cyc();
    rk_req = 1'b0;
    #1 chk("r11_valid", rk_valid, 1'b1);
    chk("r11_oor", rk_oor, 1'b1);
    chk("r11_data", rk_data, '0);
    cyc();
    #1 chk("valid_idle", rk_valid, 1'b0);

    // held off by cipher_busy, then 192-bit accept with a same-cycle read of the old key
    fill(2);
    exp_mem[24] = R12_192[127:64];
    exp_mem[25] = R12_192[63:0];
    cyc();
    cipher_busy = 1'b1; load_valid = 1'b1; load_key = K192; load_mode = 2'b01;
    #1 chk("busy_load_ready", load_ready, 1'b0);
    cyc();
    #1 chk("busy_no_start", ke_start, 1'b0);
    chk("busy_kv_kept", keys_valid, 1'b1);
    cyc();
    cipher_busy = 1'b0; rk_req = 1'b1; rk_round = 4'd10;
    #1 chk("unbusy_load_ready", load_ready, 1'b1);
    chk("accept_read_gnt", rk_gnt, 1'b1);
    cyc();
    load_valid = 1'b0; rk_req = 1'b0;
    #1 chk("unbusy_start", ke_start, 1'b1);
    chk("old_key_read", rk_data, R10_128);
    chk("kv_drop", keys_valid, 1'b0);
    chk("nr_192", num_rounds, 4'd12);
    chk("mode_192", ke_mode, 2'b01);
    cyc();
    load_valid = 1'b1; load_key = K256; load_mode = 2'b10;
    #1 chk("load_ready_in_expand", load_ready, 1'b0);
    for (int i = 0; i < 26; i++) begin
      cyc();
      write_one(i);
      if (i == 0) load_valid = 1'b0;
      if (i == 1) begin
        #1 chk("no_start_on_expand_load", ke_start, 1'b0);
        chk("key_kept_192", ke_key, K192);
      end
    end
    finish_exp();
    rd("r12_192", 4'd12, R12_192, 1'b0);
    rd("r13_192", 4'd13, '0, 1'b1);

    // 256-bit key
    fill(3);
    exp_mem[0]  = R0_256[127:64];
    exp_mem[1]  = R0_256[63:0];
    exp_mem[28] = R14_256[127:64];
    exp_mem[29] = R14_256[63:0];
    do_load(K256, 2'b10, 4'd14);
    for (int i = 0; i < 30; i++) begin
      cyc();
      write_one(i);
    end
    finish_exp();
    rd("r14_256", 4'd14, R14_256, 1'b0);
    rd("r0_256", 4'd0, R0_256, 1'b0);
    rd("r15_256", 4'd15, '0, 1'b1);
    // same-cycle write and read of one address returns the old word
    cyc();
    rk_req = 1'b1; rk_round = 4'd14;
    ke_wr = 1'b1; ke_wr_addr = 5'd28; ke_wr_data = 64'hdeadbeef00001111;
    cyc();
    ke_wr = 1'b0;
    #1 chk("rbw_old", rk_data, R14_256);
    cyc();
    rk_req = 1'b0;
    #1 chk("rbw_new", rk_data, {64'hdeadbeef00001111, exp_mem[29]});

    // expansion that never completes
    do_load(K128, 2'b00, 4'd10);
`ifdef KEY_SCHED_TIMEOUT_EN
    repeat (205) cyc();
    #1 chk("tmo_err", err, 1'b1);
    chk("tmo_idle", load_ready, 1'b1);
    chk("tmo_kv", keys_valid, 1'b0);
    do_load(K128, 2'b00, 4'd10);
    #1 chk("tmo_err_cleared", err, 1'b0);
`else
    repeat (250) cyc();
    #1 chk("wait_err", err, 1'b0);
    chk("wait_still_expand", load_ready, 1'b0);
    chk("wait_kv", keys_valid, 1'b0);
`endif
    cyc();
    reset_n = 1'b0;
    #1 chk("midrst_load_ready", load_ready, 1'b1);
    chk("midrst_num_rounds", num_rounds, 4'd10);
    chk("midrst_ke_key", ke_key, '0);
    chk("midrst_ke_mode", ke_mode, 2'b00);
    chk("midrst_kv", keys_valid, 1'b0);
    chk("midrst_err", err, 1'b0);
    cyc();
    reset_n = 1'b1;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
